// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Control and sequencing for the stopwatch counter chain. Conditions the raw
// board inputs (2-FF synchronizer plus stability-count debounce), runs the
// PAUSE / COUNT / ADJUST mode machine, and divides the system clock into the
// single-cycle strobes consumed by the minutes/seconds counters.
//
// Ports:
//   clk, rst     system clock; synchronous active-high reset
//   btn_st       raw start/stop button (asynchronous)
//   btn_clr      raw clear button (asynchronous)
//   sw_adj       raw adjust-mode switch
//   sw_sel       raw adjust select (0 = seconds, 1 = minutes)
//   cnt_en       one-cycle count strobe to the seconds counter
//   clr          one-cycle clear strobe to all counters
//   adj_sec_en   one-cycle seconds-increment strobe (ADJUST, sel = 0)
//   adj_min_en   one-cycle minutes-increment strobe (ADJUST, sel = 1)
//   blink        display blink phase, free running
//   running      high while the mode machine is in COUNT
//   adjusting    high while the mode machine is in ADJUST
//
// The strobes are plain one-cycle pulses with no back-pressure: a consumer
// must act on every cycle a strobe is high.
module stopwatch_ctrl #(
  parameter int DEB_CYCLES = 500000,
  parameter int DIV_1HZ    = 100000000,
  parameter int DIV_2HZ    = 50000000,
  parameter int DIV_BLINK  = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_st,
  input  logic btn_clr,
  input  logic sw_adj,
  input  logic sw_sel,
  output logic cnt_en,
  output logic clr,
  output logic adj_sec_en,
  output logic adj_min_en,
  output logic blink,
  output logic running,
  output logic adjusting
);

  localparam int NIN   = 4;
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int C1_W  = (DIV_1HZ    > 1) ? $clog2(DIV_1HZ)    : 1;
  localparam int C2_W  = (DIV_2HZ    > 1) ? $clog2(DIV_2HZ)    : 1;
  localparam int BL_W  = (DIV_BLINK  > 1) ? $clog2(DIV_BLINK)  : 1;

  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);
  localparam logic [C1_W-1:0]  C1_MAX  = C1_W'(DIV_1HZ - 1);
  localparam logic [C2_W-1:0]  C2_MAX  = C2_W'(DIV_2HZ - 1);
  localparam logic [BL_W-1:0]  BL_MAX  = BL_W'(DIV_BLINK - 1);

  typedef enum logic [1:0] {
    S_PAUSE  = 2'd0,
    S_COUNT  = 2'd1,
    S_ADJUST = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Input conditioning. Bit order: 0 btn_st, 1 btn_clr, 2 sw_adj, 3 sw_sel.
  // ---------------------------------------------------------------------
  logic [NIN-1:0]   raw;
  logic [NIN-1:0]   sync1;
  logic [NIN-1:0]   sync2;
  logic [NIN-1:0]   deb;
  logic [NIN-1:0]   deb_q;
  logic [DEB_W-1:0] deb_cnt [NIN];

  assign raw = {sw_sel, sw_adj, btn_clr, btn_st};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < NIN; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < NIN; i++) begin
        // The level only moves after DEB_CYCLES consecutive disagreeing
        // samples; any agreeing sample restarts the count.
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_MAX) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Button press events: registered rising edge of the debounced level,
  // which places them DEB_CYCLES+3 cycles after the raw edge.
  logic st_evt;
  logic clr_evt;
  logic adj_lvl;
  logic sel_lvl;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_evt  <= 1'b0;
      clr_evt <= 1'b0;
    end else begin
      st_evt  <= deb[0] & ~deb_q[0];
      clr_evt <= deb[1] & ~deb_q[1];
    end
  end

  assign adj_lvl = deb[2];
  assign sel_lvl = deb[3];

  // ---------------------------------------------------------------------
  // Mode machine. Priority within a cycle: clr_evt > adj_lvl > st_evt.
  // ---------------------------------------------------------------------
  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_PAUSE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_PAUSE: begin
        if (clr_evt)      state_nxt = S_PAUSE;
        else if (adj_lvl) state_nxt = S_ADJUST;
        else if (st_evt)  state_nxt = S_COUNT;
      end
      S_COUNT: begin
        if (clr_evt)      state_nxt = S_PAUSE;
        else if (adj_lvl) state_nxt = S_ADJUST;
        else if (st_evt)  state_nxt = S_PAUSE;
      end
      S_ADJUST: begin
        if (clr_evt)      state_nxt = S_ADJUST;
        else if (!adj_lvl) state_nxt = S_PAUSE;
      end
      default: state_nxt = S_PAUSE;
    endcase
  end

  assign running   = (state == S_COUNT);
  assign adjusting = (state == S_ADJUST);

  // ---------------------------------------------------------------------
  // Dividers and strobes. Both dividers sit at 0 outside their own mode, so
  // every entry starts a fresh full period.
  // ---------------------------------------------------------------------
  logic [C1_W-1:0] div_cnt;
  logic [C2_W-1:0] div_adj;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      div_adj    <= '0;
      cnt_en     <= 1'b0;
      clr        <= 1'b0;
      adj_sec_en <= 1'b0;
      adj_min_en <= 1'b0;
    end else begin
      clr        <= clr_evt;
      cnt_en     <= 1'b0;
      adj_sec_en <= 1'b0;
      adj_min_en <= 1'b0;
      // Gating on clr_evt both restarts the phase and keeps cnt_en out of
      // the cycle in which clr is high.
      if (state == S_COUNT && !clr_evt) begin
        if (div_cnt == C1_MAX) begin
          div_cnt <= '0;
          cnt_en  <= 1'b1;
        end else begin
          div_cnt <= div_cnt + C1_W'(1);
        end
      end else begin
        div_cnt <= '0;
      end
      // sel_lvl is sampled only at the wrap, so flipping it mid-period
      // redirects the next strobe without disturbing the phase.
      if (state == S_ADJUST) begin
        if (div_adj == C2_MAX) begin
          div_adj    <= '0;
          adj_sec_en <= ~sel_lvl;
          adj_min_en <= sel_lvl;
        end else begin
          div_adj <= div_adj + C2_W'(1);
        end
      end else begin
        div_adj <= '0;
      end
    end
  end

  logic [BL_W-1:0] div_blink;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_blink <= '0;
      blink     <= 1'b0;
    end else if (div_blink == BL_MAX) begin
      div_blink <= '0;
      blink     <= ~blink;
    end else begin
      div_blink <= div_blink + BL_W'(1);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl. Directed stimulus with literal expectations, plus
// a time-based reference model checked against every output on every cycle.
module tb_stopwatch_ctrl;

  localparam int DEB  = 4;
  localparam int D1   = 10;
  localparam int D2   = 5;
  localparam int DB   = 3;
  localparam int HMAX = 2047;
  localparam int M_P  = 0;
  localparam int M_C  = 1;
  localparam int M_A  = 2;

  // ---------------- clock / reset / DUT ----------------
  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic btn_st  = 1'b0;
  logic btn_clr = 1'b0;
  logic sw_adj  = 1'b0;
  logic sw_sel  = 1'b0;
  logic cnt_en, clr, adj_sec_en, adj_min_en, blink, running, adjusting;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DEB_CYCLES(DEB),
    .DIV_1HZ   (D1),
    .DIV_2HZ   (D2),
    .DIV_BLINK (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_st    (btn_st),
    .btn_clr   (btn_clr),
    .sw_adj    (sw_adj),
    .sw_sel    (sw_sel),
    .cnt_en    (cnt_en),
    .clr       (clr),
    .adj_sec_en(adj_sec_en),
    .adj_min_en(adj_min_en),
    .blink     (blink),
    .running   (running),
    .adjusting (adjusting)
  );

  // ---------------- reference model ----------------
  // t counts clock edges since the last reset edge (t = 0). raw_h holds the
  // raw input sampled at each edge; deb_h the debounced level after each
  // edge; mode_h the mode after each edge.
  bit raw_h [4][HMAX+1];
  bit deb_h [4][HMAX+1];
  int mode_h [HMAX+1];
  int t = 0;
  int cnt_entry = 0;
  int adj_entry = 0;
  bit model_ok = 1'b0;
  bit e_cnt, e_clr, e_sec, e_min, e_blink, e_run, e_adj;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %b expected %b", name, t, act, exp);
    end
  endtask

  // A press event is visible in the cycle after the debounced level rose.
  function automatic bit evt_after(input int i, input int k);
    if (k < 2) return 1'b0;
    return deb_h[i][k-1] && !deb_h[i][k-2];
  endfunction

  function automatic void model_step(input bit r, input bit [3:0] raw);
    int m;
    int nm;
    bit st_e, clr_e, adj_l, sel_l, flip, tick;
    if (r) begin
      t = 0;
      for (int i = 0; i < 4; i++) begin
        deb_h[i][0] = 1'b0;
        raw_h[i][0] = 1'b0;
      end
      mode_h[0] = M_P;
      cnt_entry = 0;
      adj_entry = 0;
      {e_cnt, e_clr, e_sec, e_min, e_blink, e_run, e_adj} = '0;
      model_ok = 1'b1;
      return;
    end
    if (!model_ok) return;
    if (t >= HMAX) begin
      errors++;
      $display("FAIL model_horizon t=%0d got overflow expected below %0d", t, HMAX);
      model_ok = 1'b0;
      return;
    end
    t++;
    for (int i = 0; i < 4; i++) begin
      raw_h[i][t] = raw[i];
      // The level flips once the synchronized value (raw two edges back)
      // has disagreed with it for DEB consecutive edges since reset.
      flip = 1'b0;
      if (t >= DEB + 2) begin
        flip = 1'b1;
        for (int j = 2; j <= DEB + 1; j++)
          if (raw_h[i][t-j] == deb_h[i][t-1]) flip = 1'b0;
      end
      deb_h[i][t] = flip ? !deb_h[i][t-1] : deb_h[i][t-1];
    end
    st_e  = evt_after(0, t - 1);
    clr_e = evt_after(1, t - 1);
    adj_l = deb_h[2][t-1];
    sel_l = deb_h[3][t-1];
    m  = mode_h[t-1];
    nm = m;
    case (m)
      M_P: if (clr_e) nm = M_P; else if (adj_l) nm = M_A; else if (st_e) nm = M_C;
      M_C: if (clr_e) nm = M_P; else if (adj_l) nm = M_A; else if (st_e) nm = M_P;
      default: if (clr_e) nm = M_A; else if (!adj_l) nm = M_P;
    endcase
    mode_h[t] = nm;
    e_cnt = (m == M_C) && ((t - cnt_entry) % D1 == 0) && !clr_e;
    tick  = (m == M_A) && ((t - adj_entry) % D2 == 0);
    e_sec = tick && !sel_l;
    e_min = tick && sel_l;
    if (nm == M_C && m != M_C) cnt_entry = t;
    if (nm == M_A && m != M_A) adj_entry = t;
    e_clr   = clr_e;
    e_run   = (nm == M_C);
    e_adj   = (nm == M_A);
    e_blink = ((t / DB) % 2) == 1;
  endfunction

  // ---------------- scoreboard: compare every cycle ----------------
  initial begin
    forever begin
      @(posedge clk);
      model_step(rst, {sw_sel, sw_adj, btn_clr, btn_st});
      @(negedge clk);
      if (model_ok) begin
        chk("sb_cnt_en",     cnt_en,     e_cnt);
        chk("sb_clr",        clr,        e_clr);
        chk("sb_adj_sec_en", adj_sec_en, e_sec);
        chk("sb_adj_min_en", adj_min_en, e_min);
        chk("sb_blink",      blink,      e_blink);
        chk("sb_running",    running,    e_run);
        chk("sb_adjusting",  adjusting,  e_adj);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cnt_en"},     cnt_en,     1'b0);
    chk({tag, "_clr"},        clr,        1'b0);
    chk({tag, "_adj_sec_en"}, adj_sec_en, 1'b0);
    chk({tag, "_adj_min_en"}, adj_min_en, 1'b0);
    chk({tag, "_blink"},      blink,      1'b0);
    chk({tag, "_running"},    running,    1'b0);
    chk({tag, "_adjusting"},  adjusting,  1'b0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    // Start/stop: event at raw edge +7, COUNT at +8, cnt_en every 10 cycles.
    do_reset(2);
    chk_all_zero("rst");
    btn_st = 1'b1;
    tick(7);  chk("t1_run_pre", running, 1'b0);
    tick(1);  chk("t1_run", running, 1'b1);
    tick(9);  chk("t1_cnt_pre", cnt_en, 1'b0);
    tick(1);  chk("t1_cnt10", cnt_en, 1'b1);
    tick(2);  btn_st = 1'b0;
    tick(8);  chk("t1_cnt20", cnt_en, 1'b1);
    tick(10); chk("t1_cnt30", cnt_en, 1'b1);
    btn_st = 1'b1;
    tick(8);  chk("t1_stop", running, 1'b0);
    tick(12); btn_st = 1'b0;
    tick(20); chk("t1_idle", running, 1'b0);

    // Bounce: 1,0,1,0 then solid high -> one event 7 cycles after the last edge.
    do_reset(2);
    btn_st = 1'b1; tick(1);
    btn_st = 1'b0; tick(1);
    btn_st = 1'b1; tick(1);
    btn_st = 1'b0; tick(1);
    btn_st = 1'b1;
    tick(7);  chk("t2_run_pre", running, 1'b0);
    tick(1);  chk("t2_run", running, 1'b1);

    // Clear and start together in COUNT, landing on a divider wrap.
    btn_st = 1'b0;
    tick(22);
    btn_clr = 1'b1;
    btn_st  = 1'b1;
    tick(8);
    chk("t3_clr", clr, 1'b1);
    chk("t3_cnt_suppressed", cnt_en, 1'b0);
    chk("t3_paused", running, 1'b0);
    tick(1);  chk("t3_clr_width", clr, 1'b0);
    btn_clr = 1'b0;
    btn_st  = 1'b0;
    tick(10);
    btn_st = 1'b1;
    tick(8);  chk("t3_restart", running, 1'b1);
    tick(9);  chk("t3_cnt_pre", cnt_en, 1'b0);
    tick(1);  chk("t3_cnt10", cnt_en, 1'b1);
    btn_st = 1'b0;
    tick(10);

    // Adjust mode: seconds strobes, select flip keeps phase, start ignored.
    do_reset(2);
    sw_sel = 1'b0;
    sw_adj = 1'b1;
    tick(6);  chk("t4_adj_pre", adjusting, 1'b0);
    tick(1);  chk("t4_adj", adjusting, 1'b1);
    tick(4);  chk("t4_sec_pre", adj_sec_en, 1'b0);
    tick(1);  chk("t4_sec", adj_sec_en, 1'b1);
              chk("t4_min_off", adj_min_en, 1'b0);
    sw_sel = 1'b1;
    tick(10); chk("t4_min", adj_min_en, 1'b1);
              chk("t4_sec_off", adj_sec_en, 1'b0);
    btn_st = 1'b1;
    tick(10); chk("t4_st_ignored", adjusting, 1'b1);
              chk("t4_not_running", running, 1'b0);
              chk("t4_min2", adj_min_en, 1'b1);
    btn_st = 1'b0;
    sw_adj = 1'b0;
    tick(6);  chk("t4_exit_pre", adjusting, 1'b1);
    tick(1);  chk("t4_exit", adjusting, 1'b0);
              chk("t4_exit_run", running, 1'b0);
    tick(10);

    // Blink phase, then reset in COUNT with the divider at 6.
    do_reset(2);
    tick(2);  chk("t5_blink2", blink, 1'b0);
    tick(1);  chk("t5_blink3", blink, 1'b1);
    tick(3);  chk("t5_blink6", blink, 1'b0);
    btn_st = 1'b1;
    tick(14); chk("t5_counting", running, 1'b1);
    rst = 1'b1;
    tick(1);
    chk_all_zero("t5_mid");
    rst = 1'b0;
    tick(3);  chk("t5_blink_restart", blink, 1'b1);
    tick(4);  chk("t5_run_pre", running, 1'b0);
    tick(1);  chk("t5_run", running, 1'b1);
    btn_st = 1'b0;
    tick(12);

    // Button held through reset: one event 7 cycles after rst falls.
    btn_st = 1'b1;
    do_reset(3);
    tick(7);  chk("t6_run_pre", running, 1'b0);
    tick(1);  chk("t6_run", running, 1'b1);
    tick(20); chk("t6_once", running, 1'b1);
    btn_st = 1'b0;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
